// File: rtl/tmr_vote_monitor_if.sv
// Bundle carrying the three data copies, their qualifier and the clear
// request into the voter, plus the voted result and health status back out.
interface tmr_vote_monitor_if #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
);
  logic [WIDTH-1:0]     inA;
  logic [WIDTH-1:0]     inB;
  logic [WIDTH-1:0]     inC;
  logic                 validIn;
  logic                 clr;
  logic [WIDTH-1:0]     out;
  logic                 validOut;
  logic                 err;
  logic                 multiErr;
  logic [CNT_WIDTH-1:0] errCntA;
  logic [CNT_WIDTH-1:0] errCntB;
  logic [CNT_WIDTH-1:0] errCntC;
  logic                 faultA;
  logic                 faultB;
  logic                 faultC;

  // Upstream triplicated logic drives the copies and reads back status
  modport master (
    output inA, inB, inC, validIn, clr,
    input  out, validOut, err, multiErr,
    input  errCntA, errCntB, errCntC, faultA, faultB, faultC
  );

  // The voter/monitor itself
  modport slave (
    input  inA, inB, inC, validIn, clr,
    output out, validOut, err, multiErr,
    output errCntA, errCntB, errCntC, faultA, faultB, faultC
  );
endinterface

// File: rtl/tmr_vote_monitor.sv
// Collapses a triplicated bus into one registered majority vote and keeps
// per-copy health: saturating mismatch counters and a sticky fault flag that
// trips after PERSIST consecutive mismatching valid samples.
module tmr_vote_monitor #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8,
  parameter int PERSIST   = 4
) (
  input  logic               clk,
  input  logic               rst,
  tmr_vote_monitor_if.slave  bus
);

  typedef enum logic [1:0] {
    LANE_OK      = 2'd0,
    LANE_SUSPECT = 2'd1,
    LANE_FAULT   = 2'd2
  } laneState_e;

  localparam logic [3:0]           PERSIST_RUN = 4'(PERSIST);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;

  logic [WIDTH-1:0]     vote;
  logic [WIDTH-1:0]     laneIn [3];
  logic [2:0]           laneMis;
  logic [CNT_WIDTH-1:0] laneCnt [3];
  logic [2:0]           laneFault;

  logic [WIDTH-1:0] out_q, out_d;
  logic             validOut_q, validOut_d;
  logic             err_q, err_d;
  logic             multiErr_q, multiErr_d;

  assign laneIn[0] = bus.inA;
  assign laneIn[1] = bus.inB;
  assign laneIn[2] = bus.inC;

  // Bitwise two-out-of-three majority of the copies
  always_comb begin
    vote = (bus.inA & bus.inB) | (bus.inB & bus.inC) | (bus.inA & bus.inC);
  end

  // A copy mismatches only on a qualified sample, however many bits differ
  always_comb begin
    laneMis = '0;
    for (int i = 0; i < 3; i++) begin
      laneMis[i] = bus.validIn && (laneIn[i] != vote);
    end
  end

  // Data path and error pulses; the vote is emitted even when it is suspect
  always_comb begin
    out_d      = out_q;
    validOut_d = bus.validIn;
    err_d      = |laneMis;
    multiErr_d = (laneMis[0] & laneMis[1]) | (laneMis[1] & laneMis[2]) |
                 (laneMis[0] & laneMis[2]);
    if (bus.validIn) begin
      out_d = vote;
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q      <= '0;
      validOut_q <= 1'b0;
      err_q      <= 1'b0;
      multiErr_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      validOut_q <= validOut_d;
      err_q      <= err_d;
      multiErr_q <= multiErr_d;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : gLane
    laneState_e           state_q, state_d;
    logic [3:0]           run_q, run_d;
    logic [3:0]           runInc;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 fault;

    // Lane state, run length and mismatch counter registers
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= LANE_OK;
        run_q   <= '0;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        run_q   <= run_d;
        cnt_q   <= cnt_d;
      end
    end

    // Next state: clear wins over a coincident mismatch, idle cycles hold
    always_comb begin
      state_d = state_q;
      run_d   = run_q;
      cnt_d   = cnt_q;
      runInc  = run_q + 4'd1;
      if (bus.clr) begin
        state_d = LANE_OK;
        run_d   = '0;
        cnt_d   = '0;
      end else if (bus.validIn) begin
        if (laneMis[g] && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
        unique case (state_q)
          LANE_OK: begin
            if (laneMis[g]) begin
              run_d   = 4'd1;
              state_d = (PERSIST_RUN == 4'd1) ? LANE_FAULT : LANE_SUSPECT;
            end
          end
          LANE_SUSPECT: begin
            if (laneMis[g]) begin
              run_d = runInc;
              if (runInc == PERSIST_RUN) begin
                state_d = LANE_FAULT;
              end
            end else begin
              run_d   = '0;
              state_d = LANE_OK;
            end
          end
          LANE_FAULT: begin
            state_d = LANE_FAULT;
          end
          default: begin
            state_d = LANE_OK;
            run_d   = '0;
          end
        endcase
      end
    end

    // Fault flag decoded straight from the registered state
    always_comb begin
      fault = (state_q == LANE_FAULT);
    end

    assign laneCnt[g]   = cnt_q;
    assign laneFault[g] = fault;
  end

  assign bus.out      = out_q;
  assign bus.validOut = validOut_q;
  assign bus.err      = err_q;
  assign bus.multiErr = multiErr_q;
  assign bus.errCntA  = laneCnt[0];
  assign bus.errCntB  = laneCnt[1];
  assign bus.errCntC  = laneCnt[2];
  assign bus.faultA   = laneFault[0];
  assign bus.faultB   = laneFault[1];
  assign bus.faultC   = laneFault[2];

endmodule

// File: tb/tb_tmr_vote_monitor.sv
// Bench for tmr_vote_monitor: a hand-derived vector table, directed corner
// sequences (counter saturation, clear priority, async reset mid-stream) and
// a randomized run checked against a counting reference model. Two instances
// share the stimulus: a default one and a narrow-counter, PERSIST=1 one.
module tb_tmr_vote_monitor;

  typedef struct packed {
    logic [7:0] out;
    logic       vo;
    logic       err;
    logic       multi;
    logic [7:0] cA;
    logic [7:0] cB;
    logic [7:0] cC;
    logic [2:0] fault;
  } obs_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic       v;
    logic       cl;
    obs_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nVectors = 0;
  int   nMiscompares = 0;

  tmr_vote_monitor_if #(.WIDTH(8), .CNT_WIDTH(8)) bus0 ();
  tmr_vote_monitor_if #(.WIDTH(8), .CNT_WIDTH(2)) bus1 ();

  tmr_vote_monitor #(.WIDTH(8), .CNT_WIDTH(8), .PERSIST(4)) dut (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  tmr_vote_monitor #(.WIDTH(8), .CNT_WIDTH(2), .PERSIST(1)) dutSmall (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  // Free-running clock, rising edge active
  always #5 clk = ~clk;

  int         maxCnt [2] = '{255, 3};
  int         persist [2] = '{4, 1};
  logic [7:0] mOut [2];
  bit         mVo [2];
  bit         mErr [2];
  bit         mMulti [2];
  int         mCnt [2][3];
  int         mRun [2][3];
  bit         mFault [2][3];

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      mOut[k] = '0; mVo[k] = 0; mErr[k] = 0; mMulti[k] = 0;
      for (int l = 0; l < 3; l++) begin
        mCnt[k][l] = 0; mRun[k][l] = 0; mFault[k][l] = 0;
      end
    end
  endtask

  // Reference: per-bit head count for the vote, run length of consecutive
  // mismatching samples for the fault, clamped integer for the counters
  task automatic modelStep(input logic [7:0] a, b, c, input logic v, cl);
    logic [7:0] cp [3];
    logic [7:0] maj;
    bit         mis [3];
    int         nm;
    cp[0] = a; cp[1] = b; cp[2] = c;
    for (int i = 0; i < 8; i++) begin
      maj[i] = ((int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2);
    end
    nm = 0;
    for (int l = 0; l < 3; l++) begin
      mis[l] = v && (cp[l] != maj);
      if (mis[l]) nm++;
    end
    for (int k = 0; k < 2; k++) begin
      mVo[k]    = v;
      mErr[k]   = (nm > 0);
      mMulti[k] = (nm >= 2);
      if (v) mOut[k] = maj;
      for (int l = 0; l < 3; l++) begin
        if (cl) begin
          mCnt[k][l] = 0; mRun[k][l] = 0; mFault[k][l] = 0;
        end else if (v) begin
          if (mis[l]) begin
            if (mCnt[k][l] < maxCnt[k]) mCnt[k][l]++;
            mRun[k][l]++;
            if (mRun[k][l] >= persist[k]) mFault[k][l] = 1;
          end else begin
            mRun[k][l] = 0;
          end
        end
      end
    end
  endtask

  function automatic obs_t modelObs(input int k);
    obs_t o;
    o.out   = mOut[k];
    o.vo    = mVo[k];
    o.err   = mErr[k];
    o.multi = mMulti[k];
    o.cA    = 8'(mCnt[k][0]);
    o.cB    = 8'(mCnt[k][1]);
    o.cC    = 8'(mCnt[k][2]);
    o.fault = {mFault[k][0], mFault[k][1], mFault[k][2]};
    return o;
  endfunction

  function automatic obs_t sample(input int k);
    obs_t o;
    if (k == 0) begin
      o.out = bus0.out; o.vo = bus0.validOut; o.err = bus0.err; o.multi = bus0.multiErr;
      o.cA = bus0.errCntA; o.cB = bus0.errCntB; o.cC = bus0.errCntC;
      o.fault = {bus0.faultA, bus0.faultB, bus0.faultC};
    end else begin
      o.out = bus1.out; o.vo = bus1.validOut; o.err = bus1.err; o.multi = bus1.multiErr;
      o.cA = 8'(bus1.errCntA); o.cB = 8'(bus1.errCntB); o.cC = 8'(bus1.errCntC);
      o.fault = {bus1.faultA, bus1.faultB, bus1.faultC};
    end
    return o;
  endfunction

  task automatic compareObs(input string name, input obs_t act, input obs_t exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got out=%h vo=%b err=%b multi=%b cnt=%h/%h/%h fault=%b, expected out=%h vo=%b err=%b multi=%b cnt=%h/%h/%h fault=%b",
               name, act.out, act.vo, act.err, act.multi, act.cA, act.cB, act.cC, act.fault,
               exp.out, exp.vo, exp.err, exp.multi, exp.cA, exp.cB, exp.cC, exp.fault);
    end
  endtask

  task automatic checkOutput(input string name, input int k);
    compareObs(name, sample(k), modelObs(k));
  endtask

  task automatic checkVal(input string name, input int act, input int exp);
    nVectors++;
    if (act != exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive both instances, advance one rising edge, step the model, and
  // return on the falling edge where outputs are sampled
  task automatic applyStimulus(input logic [7:0] a, b, c, input logic v, cl);
    bus0.inA = a; bus0.inB = b; bus0.inC = c; bus0.validIn = v; bus0.clr = cl;
    bus1.inA = a; bus1.inB = b; bus1.inC = c; bus1.validIn = v; bus1.clr = cl;
    @(posedge clk);
    modelStep(a, b, c, v, cl);
    @(negedge clk);
  endtask

  task automatic doReset();
    bus0.validIn = 1'b0; bus0.clr = 1'b0;
    bus1.validIn = 1'b0; bus1.clr = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    compareObs("reset_dut", sample(0), obs_t'(0));
    compareObs("reset_small", sample(1), obs_t'(0));
  endtask

  function automatic vec_t mk(logic [7:0] a, b, c, logic v, cl, logic [7:0] o,
                              logic vo, er, mu, logic [7:0] cA, cB, cC, logic [2:0] f);
    vec_t t;
    t.a = a; t.b = b; t.c = c; t.v = v; t.cl = cl;
    t.exp.out = o; t.exp.vo = vo; t.exp.err = er; t.exp.multi = mu;
    t.exp.cA = cA; t.exp.cB = cB; t.exp.cC = cC; t.exp.fault = f;
    return t;
  endfunction

  vec_t tv [$];

  initial begin
    bus0.inA = '0; bus0.inB = '0; bus0.inC = '0; bus0.validIn = 1'b0; bus0.clr = 1'b0;
    bus1.inA = '0; bus1.inB = '0; bus1.inC = '0; bus1.validIn = 1'b0; bus1.clr = 1'b0;

    // Expected results for the default instance (PERSIST=4, 8-bit counters)
    for (int i = 0; i < 5; i++) tv.push_back(mk(8'h5A, 8'h5A, 8'h5A, 1, 0, 8'h5A, 1, 0, 0, 0, 0, 0, 3'b000));
    tv.push_back(mk(8'h00, 8'h11, 8'h22, 0, 0, 8'h5A, 0, 0, 0, 0, 0, 0, 3'b000));
    tv.push_back(mk(8'hFF, 8'h0F, 8'h0F, 1, 0, 8'h0F, 1, 1, 0, 1, 0, 0, 3'b000));
    tv.push_back(mk(8'hFF, 8'h0F, 8'h0F, 1, 0, 8'h0F, 1, 1, 0, 2, 0, 0, 3'b000));
    tv.push_back(mk(8'hFF, 8'h0F, 8'h0F, 1, 0, 8'h0F, 1, 1, 0, 3, 0, 0, 3'b000));
    tv.push_back(mk(8'hFF, 8'h0F, 8'h0F, 1, 0, 8'h0F, 1, 1, 0, 4, 0, 0, 3'b100));
    tv.push_back(mk(8'h0F, 8'h0F, 8'h0F, 1, 0, 8'h0F, 1, 0, 0, 4, 0, 0, 3'b100));
    tv.push_back(mk(8'h0F, 8'h0F, 8'h0F, 1, 0, 8'h0F, 1, 0, 0, 4, 0, 0, 3'b100));
    tv.push_back(mk(8'h01, 8'h02, 8'h00, 1, 0, 8'h00, 1, 1, 1, 5, 1, 0, 3'b100));
    tv.push_back(mk(8'h33, 8'h33, 8'h33, 1, 1, 8'h33, 1, 0, 0, 0, 0, 0, 3'b000));
    tv.push_back(mk(8'h33, 8'hCC, 8'h33, 1, 0, 8'h33, 1, 1, 0, 0, 1, 0, 3'b000));
    tv.push_back(mk(8'h33, 8'hCC, 8'h33, 0, 0, 8'h33, 0, 0, 0, 0, 1, 0, 3'b000));
    tv.push_back(mk(8'h33, 8'hCC, 8'h33, 1, 0, 8'h33, 1, 1, 0, 0, 2, 0, 3'b000));
    tv.push_back(mk(8'h33, 8'hCC, 8'h33, 0, 0, 8'h33, 0, 0, 0, 0, 2, 0, 3'b000));
    tv.push_back(mk(8'h33, 8'hCC, 8'h33, 1, 0, 8'h33, 1, 1, 0, 0, 3, 0, 3'b000));
    tv.push_back(mk(8'h33, 8'h33, 8'h33, 1, 0, 8'h33, 1, 0, 0, 0, 3, 0, 3'b000));
    tv.push_back(mk(8'h33, 8'hCC, 8'h33, 0, 0, 8'h33, 0, 0, 0, 0, 3, 0, 3'b000));
    tv.push_back(mk(8'h33, 8'hCC, 8'h33, 1, 0, 8'h33, 1, 1, 0, 0, 4, 0, 3'b000));
    tv.push_back(mk(8'h33, 8'hCC, 8'h33, 0, 0, 8'h33, 0, 0, 0, 0, 4, 0, 3'b000));
    tv.push_back(mk(8'h33, 8'hCC, 8'h33, 1, 0, 8'h33, 1, 1, 0, 0, 5, 0, 3'b000));
    tv.push_back(mk(8'h33, 8'hCC, 8'h33, 1, 0, 8'h33, 1, 1, 0, 0, 6, 0, 3'b000));
    tv.push_back(mk(8'h33, 8'hCC, 8'h33, 1, 0, 8'h33, 1, 1, 0, 0, 7, 0, 3'b010));
    tv.push_back(mk(8'h44, 8'h44, 8'h40, 1, 1, 8'h44, 1, 1, 0, 0, 0, 0, 3'b000));
    tv.push_back(mk(8'h44, 8'h44, 8'h40, 1, 0, 8'h44, 1, 1, 0, 0, 0, 1, 3'b000));
    tv.push_back(mk(8'hF0, 8'h0F, 8'hFF, 1, 0, 8'hFF, 1, 1, 1, 1, 1, 1, 3'b000));
    tv.push_back(mk(8'h11, 8'h11, 8'h10, 1, 0, 8'h11, 1, 1, 0, 1, 1, 2, 3'b000));
    tv.push_back(mk(8'h11, 8'h11, 8'h10, 1, 0, 8'h11, 1, 1, 0, 1, 1, 3, 3'b000));
    tv.push_back(mk(8'h11, 8'h11, 8'h10, 1, 0, 8'h11, 1, 1, 0, 1, 1, 4, 3'b000));
    tv.push_back(mk(8'h11, 8'h11, 8'h10, 1, 0, 8'h11, 1, 1, 0, 1, 1, 5, 3'b001));
    tv.push_back(mk(8'h11, 8'h11, 8'h10, 1, 0, 8'h11, 1, 1, 0, 1, 1, 6, 3'b001));
    tv.push_back(mk(8'h11, 8'h11, 8'h10, 1, 1, 8'h11, 1, 1, 0, 0, 0, 0, 3'b000));
    tv.push_back(mk(8'h11, 8'h11, 8'h11, 0, 0, 8'h11, 0, 0, 0, 0, 0, 0, 3'b000));

    doReset();

    foreach (tv[i]) begin
      applyStimulus(tv[i].a, tv[i].b, tv[i].c, tv[i].v, tv[i].cl);
      compareObs($sformatf("table%0d", i), sample(0), tv[i].exp);
      checkOutput($sformatf("table%0d_small", i), 1);
    end

    // Narrow counter saturates at 3; PERSIST=1 faults on the first mismatch
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(8'h20, 8'h20, 8'h21, 1, 0);
      if (i == 0) checkVal("small_fault_first", int'(bus1.faultC), 1);
      checkOutput($sformatf("sat%0d_dut", i), 0);
      checkOutput($sformatf("sat%0d_small", i), 1);
    end
    checkVal("small_cnt_sat", int'(bus1.errCntC), 3);
    applyStimulus(8'h20, 8'h20, 8'h21, 1, 1);
    checkVal("clr_cnt", int'(bus1.errCntC), 0);
    checkVal("clr_fault", int'(bus1.faultC), 0);
    checkVal("clr_err", int'(bus1.err), 1);
    checkOutput("clr_dut", 0);

    // Async reset between edges with copy A faulty and count 7
    for (int i = 0; i < 7; i++) applyStimulus(8'h80, 8'h00, 8'h00, 1, 0);
    checkVal("pre_rst_cntA", int'(bus0.errCntA), 7);
    checkVal("pre_rst_faultA", int'(bus0.faultA), 1);
    bus0.validIn = 1'b0; bus1.validIn = 1'b0;
    #2 rst = 1'b1;
    #1;
    compareObs("async_rst_dut", sample(0), obs_t'(0));
    compareObs("async_rst_small", sample(1), obs_t'(0));
    #1 rst = 1'b0;
    modelReset();
    applyStimulus(8'h3C, 8'h3C, 8'h3C, 1, 0);
    checkVal("post_rst_out", int'(bus0.out), 8'h3C);
    checkVal("post_rst_err", int'(bus0.err), 0);
    checkOutput("post_rst_dut", 0);
    checkOutput("post_rst_small", 1);

    // Randomized run; a stuck lane per epoch exercises the fault path
    for (int n = 0; n < 600; n++) begin
      logic [7:0] base, a, b, c;
      logic       v, cl;
      int         stuck;
      stuck = (n / 40) % 4;
      base  = 8'($urandom);
      a = base; b = base; c = base;
      if (stuck == 0 || $urandom_range(4) == 0) a = base ^ 8'($urandom_range(1, 255));
      if (stuck == 1 || $urandom_range(4) == 0) b = base ^ 8'($urandom_range(1, 255));
      if (stuck == 2 || $urandom_range(4) == 0) c = base ^ 8'($urandom_range(1, 255));
      v  = ($urandom_range(3) != 0);
      cl = ($urandom_range(63) == 0);
      applyStimulus(a, b, c, v, cl);
      checkOutput($sformatf("rand%0d_dut", n), 0);
      checkOutput($sformatf("rand%0d_small", n), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
